// File: rtl/demux_4x1_if.sv
// -----------------------------------------------------------------------------
// demux_4x1_if
// Bundles the data, select, control and status signals of the registered
// 1-to-4 demultiplexer.
//   master modport (source / controller side):
//     drives  din, s0, s1, en, cnt_clr
//     reads   y0..y3, sel_q, hit0..hit3
//   slave modport (demux side): the reverse direction of every signal.
// Parameters:
//   DATA_W : width of din and of each routed output y0..y3
//   CNT_W  : width of each per-channel hit counter
// -----------------------------------------------------------------------------
interface demux_4x1_if #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] din;
    logic              s0;
    logic              s1;
    logic              en;
    logic              cnt_clr;

    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y2;
    logic [DATA_W-1:0] y3;
    logic [1:0]        sel_q;
    logic [CNT_W-1:0]  hit0;
    logic [CNT_W-1:0]  hit1;
    logic [CNT_W-1:0]  hit2;
    logic [CNT_W-1:0]  hit3;

    modport master (
        output din, s0, s1, en, cnt_clr,
        input  y0, y1, y2, y3, sel_q, hit0, hit1, hit2, hit3
    );

    modport slave (
        input  din, s0, s1, en, cnt_clr,
        output y0, y1, y2, y3, sel_q, hit0, hit1, hit2, hit3
    );
endinterface

// File: rtl/demux_4x1.sv
// -----------------------------------------------------------------------------
// demux_4x1
// Registered 1-to-4 demultiplexer with per-channel saturating hit counters.
// Each rising clk, din is loaded into the output selected by {s1,s0} when en
// is high; every other output loads zero. sel_q always loads {s1,s0}.
// A channel's hit counter increments when that channel is routed a nonzero
// value; cnt_clr clears all counters and wins over an increment.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears outputs, sel_q, counters)
//   bus   : demux_4x1_if.slave
//             in : din, s0, s1, en, cnt_clr
//             out: y0..y3, sel_q, hit0..hit3
// All outputs come straight from flops: 1-cycle latency, no comb path.
// -----------------------------------------------------------------------------
module demux_4x1 #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    demux_4x1_if.slave    bus
);

    localparam logic [CNT_W-1:0] HIT_MAX = '1;

    logic [1:0] sel;
    logic [1:0] sel_reg;

    assign sel = {bus.s1, bus.s0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg <= 2'b00;
        end else begin
            sel_reg <= sel;
        end
    end

    // One routing register and one hit counter per channel. Each channel
    // decodes its own select match, so at most one output can be nonzero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_ch
            logic              route;
            logic              hit_inc;
            logic [DATA_W-1:0] y_reg;
            logic [CNT_W-1:0]  hit_reg;

            assign route   = bus.en && (sel == 2'(gi));
            // A zero data word counts as "nothing delivered"; also stop at
            // full scale so the counter never wraps.
            assign hit_inc = route && (bus.din != '0) && (hit_reg != HIT_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y_reg   <= '0;
                    hit_reg <= '0;
                end else begin
                    y_reg <= route ? bus.din : '0;
                    if (bus.cnt_clr) begin
                        hit_reg <= '0;
                    end else if (hit_inc) begin
                        hit_reg <= hit_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign bus.y0    = gen_ch[0].y_reg;
    assign bus.y1    = gen_ch[1].y_reg;
    assign bus.y2    = gen_ch[2].y_reg;
    assign bus.y3    = gen_ch[3].y_reg;
    assign bus.hit0  = gen_ch[0].hit_reg;
    assign bus.hit1  = gen_ch[1].hit_reg;
    assign bus.hit2  = gen_ch[2].hit_reg;
    assign bus.hit3  = gen_ch[3].hit_reg;
    assign bus.sel_q = sel_reg;

endmodule

// File: tb/tb_demux_4x1.sv
// -----------------------------------------------------------------------------
// tb_demux_4x1
// Directed bench for demux_4x1 (DATA_W=1, CNT_W=8). Outputs are sampled 1 ns
// after the rising edge; inputs are changed at the same point so they are
// stable well before the next edge.
// -----------------------------------------------------------------------------
module tb_demux_4x1;

    localparam int DATA_W = 1;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    demux_4x1_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    demux_4x1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // y0..y3 packed MSB-first so 4'b1000 means "y0 only".
    logic [3:0] ys;
    assign ys = {bus.y0, bus.y1, bus.y2, bus.y3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("[%0t] ok   %s got=%0h", $time, tag, got);
        end else begin
            $display("[%0t] FAIL %s got=%0h expected=%0h", $time, tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic e, input logic d,
                         input logic clr);
        bus.s1      = s[1];
        bus.s0      = s[0];
        bus.en      = e;
        bus.din     = d;
        bus.cnt_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] onehot;
        n_checks = 0;
        n_pass   = 0;
        drive(2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        // Reset state, before any clock edge.
        check("rst_y", 32'(ys), 32'h0);
        check("rst_sel_q", 32'(bus.sel_q), 32'h0);
        check("rst_hits", 32'({bus.hit0, bus.hit1, bus.hit2, bus.hit3}), 32'h0);
        step();
        step();
        rst_n = 1'b1;   // released mid-cycle, sampled at next edge

        // Select sweep, din=1, en=1.
        for (int i = 0; i < 4; i++) begin
            drive(2'(i), 1'b1, 1'b1, 1'b0);
            step();
            onehot = 4'b1000 >> i;
            check($sformatf("sweep_y_%0d", i), 32'(ys), 32'(onehot));
            check($sformatf("sweep_sel_q_%0d", i), 32'(bus.sel_q), 32'(i));
        end
        check("sweep_hits", 32'({bus.hit0, bus.hit1, bus.hit2, bus.hit3}), 32'h01010101);

        // Data zero with enable: no output, no hit, sel_q still tracks.
        drive(2'b00, 1'b1, 1'b0, 1'b0);
        step();
        check("dzero_y", 32'(ys), 32'h0);
        check("dzero_sel_q", 32'(bus.sel_q), 32'h0);
        check("dzero_hit0", 32'(bus.hit0), 32'd1);

        // Enable gating on channel 2.
        drive(2'b10, 1'b0, 1'b1, 1'b0);
        step();
        check("engate_off_y", 32'(ys), 32'h0);
        check("engate_off_hit2", 32'(bus.hit2), 32'd1);
        check("engate_off_sel_q", 32'(bus.sel_q), 32'd2);
        drive(2'b10, 1'b1, 1'b1, 1'b0);
        step();
        check("engate_on_y", 32'(ys), 32'b0010);
        check("engate_on_hit2", 32'(bus.hit2), 32'd2);

        // Clear all counters (en=0 so nothing else moves).
        drive(2'b00, 1'b0, 1'b1, 1'b1);
        step();
        check("clr_hits", 32'({bus.hit0, bus.hit1, bus.hit2, bus.hit3}), 32'h0);

        // Saturation on channel 3.
        drive(2'b11, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 253) check("sat_hit3_254", 32'(bus.hit3), 32'd254);
            if (i == 254) check("sat_hit3_255", 32'(bus.hit3), 32'd255);
        end
        check("sat_hit3_hold", 32'(bus.hit3), 32'd255);
        check("sat_others", 32'({bus.hit0, bus.hit1, bus.hit2}), 32'h0);
        check("sat_y", 32'(ys), 32'b0001);

        // Clear priority on channel 1.
        drive(2'b00, 1'b0, 1'b0, 1'b1);
        step();
        drive(2'b01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("clrpri_hit1_5", 32'(bus.hit1), 32'd5);
        drive(2'b01, 1'b1, 1'b1, 1'b1);
        step();
        check("clrpri_hit1_0", 32'(bus.hit1), 32'd0);
        check("clrpri_y", 32'(ys), 32'b0100);
        drive(2'b01, 1'b1, 1'b1, 1'b0);
        step();
        check("clrpri_hit1_1", 32'(bus.hit1), 32'd1);

        // Async reset mid-run.
        step();
        step();
        check("areset_pre_hit1", 32'(bus.hit1), 32'd3);
        check("areset_pre_y", 32'(ys), 32'b0100);
        #2 rst_n = 1'b0;   // well between edges
        #1;
        check("areset_y", 32'(ys), 32'h0);
        check("areset_sel_q", 32'(bus.sel_q), 32'h0);
        check("areset_hits", 32'({bus.hit0, bus.hit1, bus.hit2, bus.hit3}), 32'h0);
        #2 rst_n = 1'b1;
        step();
        check("resume_y", 32'(ys), 32'b0100);
        check("resume_hit1", 32'(bus.hit1), 32'd1);
        check("resume_sel_q", 32'(bus.sel_q), 32'd1);
        drive(2'b10, 1'b1, 1'b1, 1'b0);
        step();
        check("resume2_y", 32'(ys), 32'b0010);
        check("resume2_hit2", 32'(bus.hit2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
